mem_stage: RTL and testbench

Memory-access stage of the five-stage in-order MIPS pipeline. It sits directly downstream of the execute stage and upstream of the write-back stage. It accepts one instruction per handshake from execute and captures the synchronous data-SRAM read data that arrives the cycle after execute issued the read. It extracts and extends the addressed byte, halfword or word for loads, and forwards the final result to write-back. It also drives a bypass bus toward decode.

---
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the five-stage in-order MIPS pipeline.
//               Accepts one instruction per handshake from execute and captures
//               the synchronous data-SRAM read data that arrives one cycle after
//               the read was issued. For loads it extracts the addressed
//               byte/halfword/word and sign- or zero-extends it. The result
//               goes to write-back, and the same result drives a bypass bus
//               toward decode.
// Ports       : clk, reset        - clock (rising edge), sync active-high reset
//               ws_allowin        - write-back can accept this cycle
//               ms_allowin        - this stage can accept this cycle
//               es_to_ms_valid    - execute offers an instruction
//               es_to_ms_bus      - {load_type,res_from_mem,gr_we,dest,alu_result,pc}
//               ms_to_ws_valid    - this stage offers an instruction
//               ms_to_ws_bus      - {gr_we,dest,final_result,pc}
//               data_sram_rdata   - read data for the read issued last cycle
//               ms_fwd_bus        - {fwd_we,dest,final_result} bypass to decode
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 74,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [37:0]                ms_fwd_bus
);

    localparam logic [2:0] c_LT_LB  = 3'b001;
    localparam logic [2:0] c_LT_LBU = 3'b010;
    localparam logic [2:0] c_LT_LH  = 3'b011;
    localparam logic [2:0] c_LT_LHU = 3'b100;

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_to_ms_bus;
    logic                       r_ms_fresh;
    logic [31:0]                r_rdata_buf;

    logic        w_ms_ready_go;
    logic        w_accept;
    logic [2:0]  w_load_type;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic [1:0]  w_addr;
    logic [31:0] w_load_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mem_result;
    logic [31:0] w_final_result;

    // ------------------------------------------------------------------
    // Handshake: no internal stall source, so the stage is always ready.
    // ------------------------------------------------------------------
    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_accept       = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid     <= 1'b0;
            r_ms_fresh     <= 1'b0;
            r_es_to_ms_bus <= '0;
            r_rdata_buf    <= '0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_accept) begin
                r_es_to_ms_bus <= es_to_ms_bus;
            end
            // ms_fresh marks the single cycle in which data_sram_rdata
            // belongs to the held instruction.
            r_ms_fresh <= w_accept;
            // Snapshot the SRAM word while it is still valid so a stalled
            // load keeps its data after the SRAM output moves on.
            if (r_ms_fresh) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Field decode of the registered execute payload
    // ------------------------------------------------------------------
    assign {w_load_type, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_es_to_ms_bus;
    assign w_addr = w_alu_result[1:0];

    assign w_load_word = r_ms_fresh ? data_sram_rdata : r_rdata_buf;

    // ------------------------------------------------------------------
    // Byte / halfword extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = w_load_word[7:0];
        case (w_addr)
            2'd0:    w_byte = w_load_word[7:0];
            2'd1:    w_byte = w_load_word[15:8];
            2'd2:    w_byte = w_load_word[23:16];
            default: w_byte = w_load_word[31:24];
        endcase
    end

    // addr[0] is ignored; misaligned halfwords are trapped upstream.
    assign w_half = w_addr[1] ? w_load_word[31:16] : w_load_word[15:0];

    always_comb begin
        w_mem_result = w_load_word;
        case (w_load_type)
            c_LT_LB:  w_mem_result = {{24{w_byte[7]}}, w_byte};
            c_LT_LBU: w_mem_result = {24'd0, w_byte};
            c_LT_LH:  w_mem_result = {{16{w_half[15]}}, w_half};
            c_LT_LHU: w_mem_result = {16'd0, w_half};
            default:  w_mem_result = w_load_word;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_mem_result : w_alu_result;

    assign ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_fwd_bus   = {r_ms_valid && w_gr_we, w_dest, w_final_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. A driver issues directed
//               and random transactions and pushes the expected write-back
//               payload into a scoreboard queue; a monitor pops and compares
//               whenever the stage presents an instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_fwd_bus;

    mem_stage #(
        .ES_TO_MS_BUS_WD(74),
        .MS_TO_WS_BUS_WD(70)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_fwd_bus      (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [69:0] sb[$];
    logic        m_valid  = 1'b0;
    logic        pending  = 1'b0;
    logic [73:0] pend_bus = '0;
    logic        run      = 1'b0;

    // Directed checks performed a few ns into a cycle
    logic        dchk_en  = 1'b0;
    logic [31:0] dchk_val = '0;
    logic        dchk_inv = 1'b0;
    string       dchk_name = "";

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [73:0] mk(input logic [2:0] lt, input logic rfm, input logic we,
                                       input logic [4:0] dest, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {lt, rfm, we, dest, alu, pc};
    endfunction

    // Reference: load semantics expressed with shifts and arithmetic
    function automatic logic [69:0] model(input logic [73:0] b, input logic [31:0] rd);
        logic [31:0] alu;
        int unsigned a, byt, half, mem, res;
        alu  = b[63:32];
        a    = alu % 4;
        byt  = (rd >> (8 * a)) & 32'hff;
        half = (rd >> ((a >= 2) ? 16 : 0)) & 32'hffff;
        case (b[73:71])
            3'd1:    mem = (byt >= 128) ? (byt - 256) : byt;
            3'd2:    mem = byt;
            3'd3:    mem = (half >= 32768) ? (half - 65536) : half;
            3'd4:    mem = half;
            default: mem = rd;
        endcase
        res = b[70] ? mem : alu;
        return {b[69], b[68:64], res[31:0], b[31:0]};
    endfunction

    // One clock cycle of stimulus, issued just after a rising edge.
    task automatic cycle(input logic v, input logic [73:0] b, input logic wsa,
                         input logic rst, input logic [31:0] rd);
        logic m_allow, acc;
        es_to_ms_valid  = v;
        es_to_ms_bus    = b;
        ws_allowin      = wsa;
        reset           = rst;
        data_sram_rdata = rd;
        if (pending) begin
            sb.push_back(model(pend_bus, rd));
            pending = 1'b0;
        end
        m_allow = !m_valid || wsa;
        acc     = v && m_allow;
        #2;
        if (dchk_en)  chk(dchk_name, {38'd0, ms_to_ws_bus[63:32]}, {38'd0, dchk_val});
        if (dchk_inv) begin
            chk({dchk_name, "_valid"}, {69'd0, ms_to_ws_valid}, 70'd0);
            chk({dchk_name, "_fwd_we"}, {69'd0, ms_fwd_bus[37]}, 70'd0);
        end
        dchk_en  = 1'b0;
        dchk_inv = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            pending = 1'b0;
            sb.delete();
        end else begin
            if (m_allow) m_valid = v;
            if (acc) begin
                pending  = 1'b1;
                pend_bus = b;
            end
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] val);
        dchk_en   = 1'b1;
        dchk_val  = val;
        dchk_name = name;
    endtask

    // Monitor: compare whatever the stage presents against the scoreboard head
    always @(negedge clk) begin
        if (run) begin
            chk("valid", {69'd0, ms_to_ws_valid}, {69'd0, m_valid});
            chk("allowin", {69'd0, ms_allowin}, {69'd0, (!m_valid || ws_allowin)});
            if (m_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got valid output with no expected entry at %0t", $time);
                end else begin
                    chk("ws_bus", ms_to_ws_bus, sb[0]);
                    chk("fwd_bus", {32'd0, ms_fwd_bus},
                        {32'd0, sb[0][69], sb[0][68:64], sb[0][63:32]});
                    if (ws_allowin) void'(sb.pop_front());
                end
            end else begin
                chk("fwd_we_idle", {69'd0, ms_fwd_bus[37]}, 70'd0);
            end
        end
    end

    initial begin
        logic [73:0] rb;
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b1, 1'b1, 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1, 32'd0);

        // Reset state with SRAM data at zero
        reset = 1'b0;
        #2;
        chk("rst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_allowin", {69'd0, ms_allowin}, 70'd1);
        chk("rst_fwd", {32'd0, ms_fwd_bus}, 70'd0);
        chk("rst_ws_bus", ms_to_ws_bus, 70'd0);
        run = 1'b1;
        @(posedge clk);
        #1;

        // LW
        cycle(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd9, 32'h1000_0008, 32'hBFC0_0100), 1'b1, 1'b0, $urandom);
        expect_val("lw", 32'h8765_4321);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h8765_4321);

        // Sub-word loads on 0xA1B2_C3F4
        cycle(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd1, 32'h2000_0000, 32'h100), 1'b1, 1'b0, $urandom);
        expect_val("lb0", 32'hFFFF_FFF4);
        cycle(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd2, 32'h2000_0003, 32'h104), 1'b1, 1'b0, 32'hA1B2_C3F4);
        expect_val("lbu3", 32'h0000_00A1);
        cycle(1'b1, mk(3'd3, 1'b1, 1'b1, 5'd3, 32'h2000_0002, 32'h108), 1'b1, 1'b0, 32'hA1B2_C3F4);
        expect_val("lh2", 32'hFFFF_A1B2);
        cycle(1'b1, mk(3'd4, 1'b1, 1'b1, 5'd4, 32'h2000_0000, 32'h10C), 1'b1, 1'b0, 32'hA1B2_C3F4);
        expect_val("lhu0", 32'h0000_C3F4);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'hA1B2_C3F4);

        // Stalled LW: SRAM output changes but the result must hold
        cycle(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd6, 32'h3000_0004, 32'h200), 1'b1, 1'b0, $urandom);
        expect_val("stall0", 32'h1234_5678);
        cycle(1'b0, '0, 1'b0, 1'b0, 32'h1234_5678);
        expect_val("stall1", 32'h1234_5678);
        cycle(1'b0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        expect_val("stall2", 32'h1234_5678);
        cycle(1'b0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        expect_val("stall_release", 32'h1234_5678);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);

        // Non-load then back-to-back LB
        cycle(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd5, 32'h0000_002A, 32'h300), 1'b1, 1'b0, $urandom);
        expect_val("b2b_alu", 32'h0000_002A);
        cycle(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd7, 32'h4000_0001, 32'h304), 1'b1, 1'b0, $urandom);
        expect_val("b2b_lb", 32'hFFFF_FFC3);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'hA1B2_C3F4);

        // Reset during a stalled load
        cycle(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd8, 32'h5000_0000, 32'h400), 1'b1, 1'b0, $urandom);
        cycle(1'b0, '0, 1'b0, 1'b0, 32'h0000_0055);
        cycle(1'b0, '0, 1'b0, 1'b1, $urandom);
        dchk_inv  = 1'b1;
        dchk_name = "post_reset";
        cycle(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd9, 32'h5000_0002, 32'h500), 1'b1, 1'b0, $urandom);
        expect_val("after_reset_lbu", 32'h0000_00B2);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'hA1B2_C3F4);

        // Random traffic with stalls, bubbles and occasional resets
        for (int i = 0; i < 3000; i++) begin
            rb = {$urandom_range(0, 7), 1'($urandom), 1'($urandom), 5'($urandom),
                  32'($urandom), 32'($urandom)};
            cycle(($urandom % 4) != 0, rb, ($urandom % 3) != 0, ($urandom % 150) == 0, $urandom);
        end

        // Drain
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, $urandom);
        chk("drain_empty", 70'(sb.size()), 70'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
